// File: rtl/remote_comm.sv
// Host-side UART command link: sends a 16-bit command as two 8N1 frames
// (high byte first) and receives single-byte responses from the robot.
module remote_comm #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        busy,
  output logic        cmd_snt,
  output logic        TX,
  input  logic        RX,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  input  logic        clr_resp_rdy
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_END = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF_END = BW'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} tx_state_t;
  typedef enum logic {R_IDLE, R_RCV} rx_state_t;

  tx_state_t       state, state_n;
  logic [15:0]     hold, hold_n;
  logic [BW-1:0]   baud, baud_n;
  logic [3:0]      bit_cnt, bit_n;
  logic            tx_q, tx_n;
  logic            snt_q, snt_n;
  logic [7:0]      cur;
  logic            accept;

  assign accept = (state == IDLE) && snd_cmd;

  always_comb begin
    state_n = state;
    hold_n  = hold;
    baud_n  = baud;
    bit_n   = bit_cnt;
    tx_n    = tx_q;
    snt_n   = 1'b0;
    cur     = (state == HIGH) ? hold[15:8] : hold[7:0];
    unique case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (snd_cmd) begin
          state_n = HIGH;
          hold_n  = cmd;
          baud_n  = '0;
          bit_n   = '0;
          tx_n    = 1'b0;
        end
      end
      HIGH, LOW: begin
        if (baud == BAUD_END) begin
          baud_n = '0;
          if (bit_cnt == 4'd9) begin
            bit_n = '0;
            if (state == HIGH) begin
              state_n = LOW;
              tx_n    = 1'b0;
            end else begin
              state_n = IDLE;
              tx_n    = 1'b1;
              snt_n   = 1'b1;
            end
          end else begin
            bit_n = bit_cnt + 4'd1;
            // tx_n is the level of the bit that starts next
            tx_n  = (bit_cnt == 4'd8) ? 1'b1
                                      : cur[bit_cnt[2:0]];
          end
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      hold    <= '0;
      baud    <= '0;
      bit_cnt <= '0;
      tx_q    <= 1'b1;
      snt_q   <= 1'b0;
    end else begin
      state   <= state_n;
      hold    <= hold_n;
      baud    <= baud_n;
      bit_cnt <= bit_n;
      tx_q    <= tx_n;
      snt_q   <= snt_n;
    end
  end

  assign busy    = (state != IDLE);
  assign TX      = tx_q;
  assign cmd_snt = snt_q;

  logic            rx_s1, rx_s2, rx_q;
  rx_state_t       rstate, rstate_n;
  logic [BW-1:0]   rcnt, rcnt_n;
  logic [3:0]      rbit, rbit_n;
  logic [7:0]      shreg, sh_n;
  logic [7:0]      resp_q, resp_n;
  logic            rdy_q, rdy_n;
  logic            fall, sample, set;

  assign fall   = rx_q & ~rx_s2;
  assign sample = (rbit == 4'd0) ? (rcnt == HALF_END)
                                 : (rcnt == BAUD_END);

  always_comb begin
    rstate_n = rstate;
    rcnt_n   = rcnt;
    rbit_n   = rbit;
    sh_n     = shreg;
    resp_n   = resp_q;
    set      = 1'b0;
    unique case (rstate)
      R_IDLE: begin
        if (fall) begin
          rstate_n = R_RCV;
          rcnt_n   = '0;
          rbit_n   = '0;
        end
      end
      R_RCV: begin
        if (!sample) begin
          rcnt_n = rcnt + BW'(1);
        end else begin
          rcnt_n = '0;
          rbit_n = rbit + 4'd1;
          unique case (1'b1)
            (rbit == 4'd0): begin
              if (rx_s2) begin
                rstate_n = R_IDLE;
                rbit_n   = '0;
              end
            end
            (rbit == 4'd9): begin
              rstate_n = R_IDLE;
              rbit_n   = '0;
              if (rx_s2) begin
                resp_n = shreg;
                set    = 1'b1;
              end
            end
            default: sh_n = {rx_s2, shreg[7:1]};
          endcase
        end
      end
      default: rstate_n = R_IDLE;
    endcase
    // a new byte beats a simultaneous clear
    if (set)
      rdy_n = 1'b1;
    else if (clr_resp_rdy || accept)
      rdy_n = 1'b0;
    else
      rdy_n = rdy_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1  <= 1'b1;
      rx_s2  <= 1'b1;
      rx_q   <= 1'b1;
      rstate <= R_IDLE;
      rcnt   <= '0;
      rbit   <= '0;
      shreg  <= '0;
      resp_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      rx_s1  <= RX;
      rx_s2  <= rx_s1;
      rx_q   <= rx_s2;
      rstate <= rstate_n;
      rcnt   <= rcnt_n;
      rbit   <= rbit_n;
      shreg  <= sh_n;
      resp_q <= resp_n;
      rdy_q  <= rdy_n;
    end
  end

  assign resp     = resp_q;
  assign resp_rdy = rdy_q;

endmodule
